cnt_seq_ctrl: RTL
=================

# cnt_seq_ctrl

Burst sequencer for the reloadable 7-bit terminal-count counter in the timing datapath. On `start` it latches a segment code `n` and a burst count `k`. It then runs the counter through `k` back-to-back segments of 8·n cycles each (n=0 means 128 cycles), driving the counter's load (`Q`) and count enable (`cen2`) and watching its carry `co2`. It reports one pulse per completed segment, a done strobe, and a watchdog error if the counter never carries.

## Interface
- `WD_LIMIT`, 129: number of consecutive RUN cycles without `co2` before the controller declares an error.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset; shared with the counter.
- `start` input 1: request a burst; sampled only in IDLE.
- `n` input 4: segment code; latched on an accepted start.
- `k` input 4: burst count; latched on an accepted start; 0 means 16.
- `co2` input 1: counter carry, `&{count, cen2}`; combinational from the counter.
- `Q` output 1: counter load strobe; the counter loads `128-8n`.
- `cen2` output 1: counter count enable.
- `n_o` output 4: latched `n`, fed to the counter's `n`.
- `busy` output 1: high whenever the state is not IDLE.
- `pulse` output 1: one-cycle strobe per completed segment.
- `done` output 1: one-cycle strobe after the last segment.
- `remaining` output 5: segments still to complete (1..16; 0 in IDLE).
- `err` output 1: watchdog error flag; sticky.

## Operation
- States: IDLE, LOAD, RUN, DONE. State register is binary-encoded.
- IDLE:
  - `start`=1: latch `n`→`n_o`, latch `remaining`=(k==0 ? 16 : k), clear `err`, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `Q`=1, `cen2`=0, clear watchdog counter, go to RUN.
- RUN:
  - `cen2`=1, `Q`=0.
  - If `co2`=1: `pulse`=1 in the same cycle (Mealy), decrement `remaining`. Go to DONE if the new value is 0, else go to LOAD.
  - If `co2`=0: increment the 8-bit watchdog counter. When it reaches `WD_LIMIT`, set `err` and go to IDLE with `remaining`=0. No `done`.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
- `Q`, `cen2`, `busy` and `done` are decoded from the registered state only (Moore). `pulse` is RUN & `co2`.
- Segment length in RUN cycles is 128−(128−8n mod 128) = 8n for n=1..15, and 128 for n=0. Each segment costs 8n+1 cycles including LOAD.
- `start` outside IDLE is ignored. Changes on `n`/`k` after acceptance have no effect until the next accepted start.
- `err` holds until the next accepted start or `rst`.
- Reset: state IDLE. `Q`, `cen2`, `busy`, `pulse`, `done`, `err` = 0; `remaining` = 0; `n_o` = 0; watchdog = 0. Reset takes effect immediately and asynchronously, including mid-RUN; the counter is reset by the same `rst`.

## Timing
- Start sampled at edge 0:
  - LOAD in cycle 1.
  - First RUN cycle in cycle 2.
  - First `pulse` in cycle 1+8n.
- Segment i (1-based) pulse: cycle i·(8n+1).
- `done` cycle: k·(8n+1)+1; `busy` falls in the following cycle.
- A new start can be accepted in the first IDLE cycle after DONE. There is no dead time beyond that.
- Watchdog: with RUN starting at cycle 2 and `co2` stuck low, `err`=1 and `busy`=0 from cycle 2+`WD_LIMIT`.

## Configuration
- `CNT_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort`=1 sampled in LOAD or RUN: next state IDLE, `remaining`=0, `aborted`=1 for exactly one cycle. No `pulse` in that cycle even if `co2`=1. No `done`.
  - `abort` in IDLE or DONE is ignored.
- Not defined: neither port exists, and the sequence always runs to DONE or watchdog error.

## Test plan
- n=1, k=1, start at edge 0:
  - `Q` high in cycle 1, `cen2` high in cycles 2–9.
  - `pulse` in cycle 9, `done` in cycle 10.
  - `busy` high in cycles 1–10, `remaining` 1→0 at edge after cycle 9.
- n=2, k=3: pulses in cycles 17, 34, 51; `done` in cycle 52; `remaining` steps 3→2→1→0.
- n=0, k=0: 16 segments of 128 RUN cycles; pulses every 129 cycles; `done` in cycle 2065.
- `start` pulsed in cycle 5 of the n=1, k=1 run: ignored, identical waveform. `rst` asserted in cycle 4: all outputs 0 immediately, state IDLE, counter cleared.
- `co2` tied 0, n=1, k=1: `err`=1 and `busy`=0 from cycle 131, no `pulse`/`done`. A following start clears `err`.
- With `CNT_SEQ_ABORT_EN`: n=3, k=2, `abort` in cycle 10 → `aborted`=1 in cycle 11, `busy`=0 in cycle 11, no `done`, `remaining`=0.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: burst sequencer for the reloadable 7-bit terminal-count counter.
// Runs k back-to-back segments of 8n cycles (n=0 -> 128), one pulse per segment,
// a done strobe at the end, and a sticky watchdog error if co2 never arrives.
// Optional feature macro: CNT_SEQ_ABORT_EN adds the abort input / aborted output.
module cnt_seq_ctrl #(
  parameter int unsigned WD_LIMIT = 129
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n,
  input  logic [3:0] k,
  input  logic       co2,
  output logic       Q,
  output logic       cen2,
  output logic [3:0] n_o,
  output logic       busy,
  output logic       pulse,
  output logic       done,
  output logic [4:0] remaining,
  output logic       err
`ifdef CNT_SEQ_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       abort_hit;

`ifdef CNT_SEQ_ABORT_EN
  logic aborted_q, aborted_d;

  // Abort only counts while the counter is actually being driven.
  assign abort_hit = abort && ((state_q == LOAD) || (state_q == RUN));
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Moore decodes of the registered state; pulse is the only Mealy output.
  assign Q         = (state_q == LOAD);
  assign cen2      = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pulse     = (state_q == RUN) && co2 && !abort_hit;
  assign n_o       = n_q;
  assign remaining = rem_q;
  assign err       = err_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rem_d   = rem_q;
    wd_d    = wd_q;
    err_d   = err_q;
`ifdef CNT_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n;
          rem_d   = (k == 4'd0) ? 5'd16 : {1'b0, k};
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        if (co2) begin
          rem_d   = rem_q - 5'd1;
          state_d = (rem_q == 5'd1) ? DONE : LOAD;
        end else begin
          wd_d = wd_q + 8'd1;
          if (wd_d == 8'(WD_LIMIT)) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever LOAD/RUN decided above, including a co2 hit.
    if (abort_hit) begin
      rem_d   = '0;
      state_d = IDLE;
`ifdef CNT_SEQ_ABORT_EN
      aborted_d = 1'b1;
`endif
    end
  end

  // State and datapath registers, asynchronously cleared with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

`ifdef CNT_SEQ_ABORT_EN
  // One-cycle abort acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= aborted_d;
  end
`endif

endmodule
